// File: rtl/instruction_fetch.sv
// Fetch stage: PC, imem req/ack, IR to decoder; IFETCH_TIMEOUT_EN adds the fetch timeout.
// Latency: ack at N gives ir_valid at N+1. Backpressure: stall holds ISSUE with IR and pc frozen.
module instruction_fetch #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [3:0]      opcode,
  output logic [3:0]      DA,
  output logic [3:0]      SA,
  output logic [3:0]      SB,
  output logic            ir_valid,
  input  logic            stall,
  input  logic            take_branch,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fetch_err
);

  typedef enum logic [1:0] {
    s_idle,
    s_wait,
    s_issue,
    s_halt
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic        ir_load;
  logic        pc_inc;
  logic        pc_branch;
  logic        tmo_hit;
  logic        is_halt;

  // HALT is opcode 1111 with DA 1111; opcode 1111 with any other DA is a NOP
  assign is_halt = (ir[15:8] == 8'hFF);

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // Fires on the TIMEOUT-th consecutive WAIT cycle without ack; an ack that cycle still wins
  assign tmo_hit = (state == s_wait) && !imem_ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state_nxt == s_wait) && (state != s_wait)) begin
        tmo_cnt <= '0;
      end else if ((state == s_wait) && !imem_ack) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fetch_err = err_q;
`else
  assign tmo_hit   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    case (state)
      s_idle: begin
        state_nxt = s_wait;
      end
      s_wait: begin
        if (imem_ack) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = s_issue;
        end else if (tmo_hit) begin
          state_nxt = s_halt;
        end
      end
      s_issue: begin
        if (!stall) begin
          if (is_halt) begin
            state_nxt = s_halt;
          end else begin
            pc_branch = take_branch;
            state_nxt = s_wait;
          end
        end
      end
      s_halt: begin
        state_nxt = s_halt;
      end
      default: begin
        state_nxt = s_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= s_idle;
      ir    <= 16'h0000;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      if (ir_load) begin
        ir <= imem_data;
      end
      // The increment wraps naturally at 2^PC_W
      if (pc_branch) begin
        pc <= branch_target;
      end else if (pc_inc) begin
        pc <= pc + 1'b1;
      end
    end
  end

  assign imem_req  = (state == s_wait);
  assign imem_addr = pc;
  assign ir_valid  = (state == s_issue);
  assign halted    = (state == s_halt);
  assign opcode    = ir[15:12];
  assign DA        = ir[11:8];
  assign SA        = ir[7:4];
  assign SB        = ir[3:0];

endmodule
